// File: rtl/mbist_seq_if.sv
// SRAM-side bus of the MBIST sequencer: the BIST drives the access, the memory returns read data.
`timescale 1ns/1ps
interface mbist_seq_if #(
    parameter int ADDR_WD = 9,
    parameter int DATA_WD = 32
);
    logic               mem_en;
    logic               mem_we;
    logic [ADDR_WD-1:0] mem_addr;
    logic [DATA_WD-1:0] mem_wdata;
    logic [DATA_WD-1:0] mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mbist_seq.sv
// March C- address/data sequencer for SRAM BIST: op/address/stimulus/pattern counters,
// SRAM access generation and sticky first-failure capture.
`timescale 1ns/1ps
module mbist_seq #(
    parameter int                    BIST_ADDR_WD    = 9,
    parameter int                    BIST_DATA_WD    = 32,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bist_run,
    input  logic                    cmd_phase,
    input  logic                    cmp_phase,
    input  logic                    run_op,
    input  logic                    run_addr,
    input  logic                    run_sti,
    input  logic                    run_pat,
    mbist_seq_if.master             mem,
    output logic                    last_op,
    output logic                    last_addr,
    output logic                    last_sti,
    output logic                    last_pat,
    output logic                    op_reverse,
    output logic                    bist_error,
    output logic [BIST_ADDR_WD-1:0] err_addr,
    output logic [BIST_DATA_WD-1:0] err_rdata
);

    typedef enum logic [2:0] {
        STI_W0_UP   = 3'd0,
        STI_R0W1_UP = 3'd1,
        STI_R1W0_UP = 3'd2,
        STI_R0W1_DN = 3'd3,
        STI_R1W0_DN = 3'd4,
        STI_R0_UP   = 3'd5
    } sti_e;

    localparam int PAT_REP = (BIST_DATA_WD + 31) / 32;

    sti_e                    sti;
    sti_e                    sti_next;
    logic                    op;
    logic [BIST_ADDR_WD-1:0] addr;
    logic [1:0]              pat;

    logic                    cur_up;
    logic                    next_up;
    logic                    two_ops;
    logic                    op_rd;
    logic                    op_d1;
    logic [31:0]             pat_word;
    logic [PAT_REP*32-1:0]   pat_rep;
    logic [BIST_DATA_WD-1:0] data_exp;
    logic                    miscompare;

    // Stimulus table: element order, direction and the read/data polarity of the current op.
    always_comb begin
        sti_next = STI_W0_UP;
        two_ops  = 1'b1;
        op_rd    = 1'b0;
        op_d1    = 1'b0;
        case (sti)
            STI_W0_UP: begin
                sti_next = STI_R0W1_UP;
                two_ops  = 1'b0;
            end
            STI_R0W1_UP: begin
                sti_next = STI_R1W0_UP;
                op_rd    = ~op;
                op_d1    = op;
            end
            STI_R1W0_UP: begin
                sti_next = STI_R0W1_DN;
                op_rd    = ~op;
                op_d1    = ~op;
            end
            STI_R0W1_DN: begin
                sti_next = STI_R1W0_DN;
                op_rd    = ~op;
                op_d1    = op;
            end
            STI_R1W0_DN: begin
                sti_next = STI_R0_UP;
                op_rd    = ~op;
                op_d1    = ~op;
            end
            STI_R0_UP: begin
                sti_next = STI_W0_UP;
                two_ops  = 1'b0;
                op_rd    = 1'b1;
            end
            default: begin
                sti_next = STI_W0_UP;
                two_ops  = 1'b0;
            end
        endcase
    end

    assign cur_up  = !(sti == STI_R0W1_DN || sti == STI_R1W0_DN);
    assign next_up = !(sti_next == STI_R0W1_DN || sti_next == STI_R1W0_DN);

    always_comb begin
        pat_word = 32'h0000_0000;
        case (pat)
            2'd0:    pat_word = 32'h0000_0000;
            2'd1:    pat_word = 32'h5555_5555;
            2'd2:    pat_word = 32'h3333_3333;
            2'd3:    pat_word = 32'h0F0F_0F0F;
            default: pat_word = 32'h0000_0000;
        endcase
    end

    // The 32-bit pattern is tiled so any data width takes its LSBs.
    assign pat_rep  = {PAT_REP{pat_word}};
    assign data_exp = op_d1 ? ~pat_rep[BIST_DATA_WD-1:0] : pat_rep[BIST_DATA_WD-1:0];

    assign last_op    = two_ops ? op : ~op;
    assign last_addr  = cur_up ? (addr == BIST_ADDR_END) : (addr == BIST_ADDR_START);
    assign last_sti   = (sti == STI_R0_UP);
    assign last_pat   = (pat == 2'd3);
    assign op_reverse = (cur_up != next_up);

    assign mem.mem_en    = cmd_phase;
    assign mem.mem_we    = cmd_phase & ~op_rd;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = data_exp;

    assign miscompare = cmp_phase & op_rd & (mem.mem_rdata != data_exp);

    // Sequence counters; a new stimulus either reloads the address for its direction or,
    // on a direction reversal, keeps the end address as its first access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op   <= 1'b0;
            addr <= BIST_ADDR_START;
            sti  <= STI_W0_UP;
            pat  <= 2'd0;
        end else if (!bist_run) begin
            op   <= 1'b0;
            addr <= BIST_ADDR_START;
            sti  <= STI_W0_UP;
            pat  <= 2'd0;
        end else begin
            if (run_op) begin
                op <= last_op ? 1'b0 : op + 1'b1;
            end
            if (run_addr) begin
                if (run_sti) begin
                    addr <= next_up ? BIST_ADDR_START : BIST_ADDR_END;
                end else begin
                    addr <= cur_up ? addr + 1'b1 : addr - 1'b1;
                end
            end
            if (run_sti) begin
                sti <= sti_next;
            end
            if (run_pat) begin
                pat <= pat + 2'd1;
            end
        end
    end

    // Sticky error; only the first miscompare is recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bist_error <= 1'b0;
            err_addr   <= '0;
            err_rdata  <= '0;
        end else if (!bist_run) begin
            bist_error <= 1'b0;
            err_addr   <= '0;
            err_rdata  <= '0;
        end else if (miscompare) begin
            bist_error <= 1'b1;
            if (!bist_error) begin
                err_addr  <= addr;
                err_rdata <= mem.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mbist_seq.sv
// Bench for mbist_seq: plays the BIST controller and an SRAM model, with a scoreboard of
// expected accesses and flags checked by a monitor on every cmd_phase cycle.
`timescale 1ns/1ps
module tb_mbist_seq;

    localparam int             AW      = 9;
    localparam int             DW      = 32;
    localparam logic [AW-1:0]  A_START = 9'h000;
    localparam logic [AW-1:0]  A_END   = 9'h1F8;
    localparam int             NADDR   = 505;
    localparam logic [AW-1:0]  F1_ADDR = 9'h010;
    localparam logic [AW-1:0]  F2_ADDR = 9'h020;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bist_run;
    logic          cmd_phase;
    logic          cmp_phase;
    logic          run_op;
    logic          run_addr;
    logic          run_sti;
    logic          run_pat;
    logic          last_op;
    logic          last_addr;
    logic          last_sti;
    logic          last_pat;
    logic          op_reverse;
    logic          bist_error;
    logic [AW-1:0] err_addr;
    logic [DW-1:0] err_rdata;

    mbist_seq_if #(.ADDR_WD(AW), .DATA_WD(DW)) bus ();

    mbist_seq #(
        .BIST_ADDR_WD   (AW),
        .BIST_DATA_WD   (DW),
        .BIST_ADDR_START(A_START),
        .BIST_ADDR_END  (A_END)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bist_run  (bist_run),
        .cmd_phase (cmd_phase),
        .cmp_phase (cmp_phase),
        .run_op    (run_op),
        .run_addr  (run_addr),
        .run_sti   (run_sti),
        .run_pat   (run_pat),
        .mem       (bus),
        .last_op   (last_op),
        .last_addr (last_addr),
        .last_sti  (last_sti),
        .last_pat  (last_pat),
        .op_reverse(op_reverse),
        .bist_error(bist_error),
        .err_addr  (err_addr),
        .err_rdata (err_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          l_op;
        logic          l_addr;
        logic          l_sti;
        logic          l_pat;
        logic          rev;
    } access_t;

    access_t exp_q[$];
    access_t mon_act;
    access_t mon_exp;
    int      tests_run    = 0;
    int      tests_failed = 0;

    // March C- as written in the test plan: S0 up W0; S1 up R0,W1; S2 up R1,W0;
    // S3 down R0,W1; S4 down R1,W0; S5 up R0.
    int          n_ops  [6]    = '{1, 2, 2, 2, 2, 1};
    bit          dir_up [6]    = '{1, 1, 1, 0, 0, 1};
    bit          is_rd  [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
    bit          is_d1  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
    logic [31:0] pats   [4]    = '{32'h0000_0000, 32'h5555_5555, 32'h3333_3333, 32'h0F0F_0F0F};

    int m_pat;
    int m_sti;
    int m_ai;
    int m_op;
    bit m_done;

    // SRAM model with optional stuck-at-1 faults applied on the read path.
    logic [31:0] sram [512];
    logic [31:0] rd_word;
    bit          f1_en;
    bit          f2_en;

    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) begin
                sram[bus.mem_addr] <= bus.mem_wdata;
            end else begin
                rd_word = sram[bus.mem_addr];
                if (f1_en && bus.mem_addr == F1_ADDR) rd_word[0] = 1'b1;
                if (f2_en && bus.mem_addr == F2_ADDR) rd_word[1] = 1'b1;
                bus.mem_rdata <= rd_word;
            end
        end
    end

    // Scoreboard monitor: every enabled access must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            mon_act = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata,
                        l_op: last_op, l_addr: last_addr, l_sti: last_sti,
                        l_pat: last_pat, rev: op_reverse};
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL access: unexpected access got addr=%h we=%b, required none",
                         mon_act.addr, mon_act.we);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL access: got we=%b addr=%h wdata=%h op/addr/sti/pat/rev=%b%b%b%b%b, required we=%b addr=%h wdata=%h op/addr/sti/pat/rev=%b%b%b%b%b",
                             mon_act.we, mon_act.addr, mon_act.wdata, mon_act.l_op, mon_act.l_addr,
                             mon_act.l_sti, mon_act.l_pat, mon_act.rev,
                             mon_exp.we, mon_exp.addr, mon_exp.wdata, mon_exp.l_op, mon_exp.l_addr,
                             mon_exp.l_sti, mon_exp.l_pat, mon_exp.rev);
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_pat  = 0;
        m_sti  = 0;
        m_ai   = 0;
        m_op   = 0;
        m_done = 1'b0;
    endtask

    function automatic logic [AW-1:0] model_addr();
        return dir_up[m_sti] ? A_START + AW'(m_ai) : A_END - AW'(m_ai);
    endfunction

    // One access: cmd cycle, then cmp cycle carrying the advance strobes. Entered and left at posedge+1.
    task automatic apply_stimulus();
        access_t e;
        bit      lop;
        bit      laddr;
        bit      lsti;
        bit      lpat;
        int      nxt;
        nxt   = (m_sti == 5) ? 0 : m_sti + 1;
        lop   = (m_op == n_ops[m_sti] - 1);
        laddr = (m_ai == NADDR - 1);
        lsti  = (m_sti == 5);
        lpat  = (m_pat == 3);
        e.we     = !is_rd[m_sti][m_op];
        e.addr   = model_addr();
        e.wdata  = is_d1[m_sti][m_op] ? ~pats[m_pat] : pats[m_pat];
        e.l_op   = lop;
        e.l_addr = laddr;
        e.l_sti  = lsti;
        e.l_pat  = lpat;
        e.rev    = (dir_up[m_sti] != dir_up[nxt]);
        exp_q.push_back(e);
        cmd_phase = 1'b1;
        @(posedge clk); #1;
        cmd_phase = 1'b0;
        cmp_phase = 1'b1;
        if (lop && laddr && lsti && lpat) begin
            m_done = 1'b1;
        end else begin
            run_op   = 1'b1;
            run_addr = lop && !(laddr && e.rev);
            run_sti  = lop && laddr;
            run_pat  = lop && laddr && lsti;
        end
        @(posedge clk); #1;
        cmp_phase = 1'b0;
        run_op    = 1'b0;
        run_addr  = 1'b0;
        run_sti   = 1'b0;
        run_pat   = 1'b0;
        if (!m_done) begin
            if (!lop) begin
                m_op++;
            end else begin
                m_op = 0;
                if (!laddr) begin
                    m_ai++;
                end else begin
                    m_ai = 0;
                    if (!lsti) begin
                        m_sti++;
                    end else begin
                        m_sti = 0;
                        m_pat = (m_pat + 1) % 4;
                    end
                end
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        bist_run  = 1'b0;
        cmd_phase = 1'b0;
        cmp_phase = 1'b0;
        run_op    = 1'b0;
        run_addr  = 1'b0;
        run_sti   = 1'b0;
        run_pat   = 1'b0;
        f1_en     = 1'b0;
        f2_en     = 1'b0;
        model_reset();

        #12;
        check_output("reset last_op",    64'(last_op),      64'd1);
        check_output("reset last_addr",  64'(last_addr),    64'd0);
        check_output("reset last_sti",   64'(last_sti),     64'd0);
        check_output("reset last_pat",   64'(last_pat),     64'd0);
        check_output("reset op_reverse", 64'(op_reverse),   64'd0);
        check_output("reset bist_error", 64'(bist_error),   64'd0);
        check_output("reset err_addr",   64'(err_addr),     64'd0);
        check_output("reset err_rdata",  64'(err_rdata),    64'd0);
        check_output("reset mem_en",     64'(bus.mem_en),   64'd0);
        check_output("reset mem_addr",   64'(bus.mem_addr), 64'd0);

        @(posedge clk); #1;
        rst_n    = 1'b1;
        bist_run = 1'b1;

        // Full clean run over all four patterns.
        while (!m_done) apply_stimulus();
        check_output("full run last_op",    64'(last_op),      64'd1);
        check_output("full run last_addr",  64'(last_addr),    64'd1);
        check_output("full run last_sti",   64'(last_sti),     64'd1);
        check_output("full run last_pat",   64'(last_pat),     64'd1);
        check_output("full run bist_error", 64'(bist_error),   64'd0);
        check_output("full run mem_addr",   64'(bus.mem_addr), 64'h1F8);

        bist_run = 1'b0;
        @(posedge clk); #1;
        check_output("sync clear last_sti", 64'(last_sti),     64'd0);
        check_output("sync clear last_pat", 64'(last_pat),     64'd0);
        check_output("sync clear mem_addr", 64'(bus.mem_addr), 64'd0);
        bist_run = 1'b1;

        // Stuck-at-1 bit 0 at 0x010 and bit 1 at 0x020; first detection is S1 R0 at 0x010.
        model_reset();
        f1_en = 1'b1;
        f2_en = 1'b1;
        repeat (537) apply_stimulus();
        check_output("pre-fault bist_error", 64'(bist_error), 64'd0);
        apply_stimulus();
        check_output("fault1 bist_error", 64'(bist_error), 64'd1);
        check_output("fault1 err_addr",   64'(err_addr),   64'h010);
        check_output("fault1 err_rdata",  64'(err_rdata),  64'h0000_0001);

        repeat (32) apply_stimulus();
        check_output("fault2 bist_error", 64'(bist_error), 64'd1);
        check_output("fault2 err_addr",   64'(err_addr),   64'h010);
        check_output("fault2 err_rdata",  64'(err_rdata),  64'h0000_0001);

        // Advance into the middle of S3, then abort.
        repeat (2525 + 50 - 570) apply_stimulus();
        check_output("mid-S3 mem_addr", 64'(bus.mem_addr), 64'(A_END - 9'd25));
        bist_run = 1'b0;
        @(posedge clk); #1;
        check_output("abort bist_error", 64'(bist_error),   64'd0);
        check_output("abort err_addr",   64'(err_addr),     64'd0);
        check_output("abort err_rdata",  64'(err_rdata),    64'd0);
        check_output("abort last_sti",   64'(last_sti),     64'd0);
        check_output("abort last_op",    64'(last_op),      64'd1);
        check_output("abort mem_addr",   64'(bus.mem_addr), 64'd0);
        check_output("abort op_reverse", 64'(op_reverse),   64'd0);
        bist_run = 1'b1;
        f1_en    = 1'b0;
        f2_en    = 1'b0;
        model_reset();
        repeat (40) apply_stimulus();
        check_output("rerun bist_error", 64'(bist_error),   64'd0);
        check_output("rerun mem_addr",   64'(bus.mem_addr), 64'h028);

        // Asynchronous reset between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async rst mem_addr",  64'(bus.mem_addr), 64'd0);
        check_output("async rst last_op",   64'(last_op),      64'd1);
        check_output("async rst last_addr", 64'(last_addr),    64'd0);
        check_output("async rst bist_err",  64'(bist_error),   64'd0);
        @(posedge clk); #1;
        check_output("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
